// File: rtl/call_stack.sv
// Hardware return-address stack: DEPTH x WIDTH registers addressed by count,
// with a combinational top-of-stack read and sticky overflow/underflow flags.
module call_stack #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stack_push,
   input  logic                       stack_pop,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       stack_overflow,
   output logic                       stack_underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] entry [DEPTH];
   logic [PW:0]      count_q;
   logic [PW:0]      count_d;
   logic [PW-1:0]    top_idx;
   logic [PW-1:0]    wr_idx;
   logic             we;
   logic             ov_set;
   logic             un_set;
   logic             ov_q;
   logic             un_q;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_C);
   assign count    = count_q;
   // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
   assign top_idx  = count_q[PW-1:0] - PW'(1);
   assign data_out = empty ? '0 : entry[top_idx];
   assign stack_overflow  = ov_q;
   assign stack_underflow = un_q;

   always_comb begin
      count_d = count_q;
      wr_idx  = count_q[PW-1:0];
      we      = 1'b0;
      ov_set  = 1'b0;
      un_set  = 1'b0;
      case ({stack_push, stack_pop})
         2'b10: begin
            if (full) begin
               ov_set = 1'b1;
            end else begin
               we      = 1'b1;
               count_d = count_q + (PW+1)'(1);
            end
         end
         2'b01: begin
            if (empty) begin
               un_set = 1'b1;
            end else begin
               count_d = count_q - (PW+1)'(1);
            end
         end
         2'b11: begin
            // Push+pop on an empty stack degenerates to a plain push.
            we = 1'b1;
            if (empty) begin
               count_d = (PW+1)'(1);
            end else begin
               wr_idx = top_idx;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ov_q    <= 1'b0;
         un_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         ov_q    <= ov_q | ov_set;
         un_q    <= un_q | un_set;
      end
   end

   // Entries are deliberately not reset; they are hidden while the stack is empty.
   always_ff @(posedge clk) begin
      if (!rst && we) begin
         entry[wr_idx] <= data_in;
      end
   end

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_call_stack;

   localparam int WIDTH = 12;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stack_push = 1'b0;
   logic             stack_pop = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [WIDTH-1:0] data_out;
   logic [3:0]       count;
   logic             empty;
   logic             full;
   logic             stack_overflow;
   logic             stack_underflow;

   int checks = 0;
   int errors = 0;

   // model state
   logic [WIDTH-1:0] m_q[$];
   logic             m_ov = 1'b0;
   logic             m_un = 1'b0;
   logic             m_valid = 1'b0;

   call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .stack_push(stack_push),
      .stack_pop(stack_pop),
      .data_in(data_in),
      .data_out(data_out),
      .count(count),
      .empty(empty),
      .full(full),
      .stack_overflow(stack_overflow),
      .stack_underflow(stack_underflow)
   );

   // clock
   always #5 clk = ~clk;

   // behavioural model, advanced on each rising edge from the applied inputs
   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
         m_valid = 1'b1;
      end else if (stack_push && stack_pop) begin
         if (m_q.size() == 0) m_q.push_back(data_in);
         else m_q[m_q.size()-1] = data_in;
      end else if (stack_push) begin
         if (m_q.size() == DEPTH) m_ov = 1'b1;
         else m_q.push_back(data_in);
      end else if (stack_pop) begin
         if (m_q.size() == 0) m_un = 1'b1;
         else void'(m_q.pop_back());
      end
   end

   // scoreboard compare, once per cycle on the falling edge
   always @(negedge clk) begin
      logic [WIDTH-1:0] e_dout;
      logic [3:0]       e_cnt;
      if (m_valid) begin
         e_cnt  = 4'(m_q.size());
         e_dout = (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
         checks++;
         if (data_out !== e_dout || count !== e_cnt || empty !== (m_q.size() == 0) ||
             full !== (m_q.size() == DEPTH) || stack_overflow !== m_ov ||
             stack_underflow !== m_un) begin
            errors++;
            $display("FAIL model_cmp t=%0t: dout=%h cnt=%0d e=%b f=%b ov=%b un=%b, want dout=%h cnt=%0d e=%b f=%b ov=%b un=%b",
                     $time, data_out, count, empty, full, stack_overflow, stack_underflow,
                     e_dout, e_cnt, (m_q.size() == 0), (m_q.size() == DEPTH), m_ov, m_un);
         end
      end
   end

   // driver: apply one cycle of inputs, return 1ns after the edge
   task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic r);
      stack_push = p;
      stack_pop  = q;
      data_in    = d;
      rst        = r;
      @(posedge clk);
      #1;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      rst        = 1'b0;
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      step(1'b1, 1'b0, d, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 1'b1, '0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      do_reset();
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_dout", 32'(data_out), 0);

      // basic push/pop
      push(12'h010); push(12'h020); push(12'h030);
      check("p3_count", 32'(count), 3);
      check("p3_dout", 32'(data_out), 32'h030);
      pop();
      check("pop_dout", 32'(data_out), 32'h020);
      check("pop_count", 32'(count), 2);

      // fill and overflow
      do_reset();
      for (int i = 1; i <= 8; i++) push(12'(i));
      check("fill_full", 32'(full), 1);
      check("fill_dout", 32'(data_out), 32'h008);
      push(12'h0FF);
      check("ovf_flag", 32'(stack_overflow), 1);
      check("ovf_count", 32'(count), 8);
      check("ovf_dout", 32'(data_out), 32'h008);

      // underflow
      do_reset();
      pop();
      check("unf_flag", 32'(stack_underflow), 1);
      check("unf_count", 32'(count), 0);
      check("unf_dout", 32'(data_out), 0);
      push(12'h123);
      check("unf_push_count", 32'(count), 1);
      check("unf_sticky", 32'(stack_underflow), 1);
      check("unf_push_dout", 32'(data_out), 32'h123);

      // simultaneous push+pop
      do_reset();
      push(12'h030); push(12'h040);
      step(1'b1, 1'b1, 12'h0AB, 1'b0);
      check("pp_count", 32'(count), 2);
      check("pp_dout", 32'(data_out), 32'h0AB);
      pop();
      check("pp_below", 32'(data_out), 32'h030);
      pop();
      step(1'b1, 1'b1, 12'h055, 1'b0);
      check("ppe_count", 32'(count), 1);
      check("ppe_dout", 32'(data_out), 32'h055);
      check("ppe_unf", 32'(stack_underflow), 0);

      // reset mid-sequence with a pending push
      do_reset();
      pop();
      for (int i = 0; i < 9; i++) push(12'h100 + 12'(i));
      pop(); pop(); pop();
      check("pre_rst_count", 32'(count), 5);
      check("pre_rst_flags", 32'({stack_overflow, stack_underflow}), 3);
      step(1'b1, 1'b0, 12'h777, 1'b1);
      check("mid_rst_count", 32'(count), 0);
      check("mid_rst_empty", 32'(empty), 1);
      check("mid_rst_flags", 32'({stack_overflow, stack_underflow}), 0);
      check("mid_rst_dout", 32'(data_out), 0);

      // randomized traffic with push-heavy / pop-heavy phases
      for (int ph = 0; ph < 16; ph++) begin
         int bias;
         bias = (ph % 2 == 0) ? 75 : 25;
         for (int c = 0; c < 150; c++) begin
            int r;
            logic p, q;
            r = int'($urandom_range(99, 0));
            p = (r < bias);
            q = (int'($urandom_range(99, 0)) < (100 - bias));
            step(p, q, 12'($urandom), ($urandom_range(299, 0) == 0));
         end
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, the bit width of one stored return address.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of stack entries (power of two, >= 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port stack_push  input  1  push request for the current cycle.
REQ-006 The block SHALL have port stack_pop  input  1  pop request for the current cycle.
REQ-007 The block SHALL have port data_in  input  WIDTH  address to push (next PC of the call).
REQ-008 The block SHALL have port data_out  output  WIDTH  current top of stack (return address).
REQ-009 The block SHALL have port count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-010 The block SHALL have port empty  output  1  high when count == 0.
REQ-011 The block SHALL have port full  output  1  high when count == DEPTH.
REQ-012 The block SHALL have port stack_overflow  output  1  sticky flag: push attempted while full.
REQ-013 The block SHALL have port stack_underflow  output  1  sticky flag: pop attempted while empty.

Function
REQ-014 The storage SHALL be DEPTH registers of WIDTH bits, indexed by a stack pointer equal to count (next free slot).
REQ-015 data_out SHALL be combinational: entry[count-1] when count > 0, all zeros when empty; a pop's value is therefore usable in the same cycle by a single-cycle datapath.
REQ-016 empty, full and count SHALL be combinational decodes of the pointer with no added latency.
REQ-017 Push only, not full: entry[count] <= data_in and count <= count+1 at the edge.
REQ-018 Pop only, not empty: count <= count-1 at the edge; stored entries unchanged.
REQ-019 Push and pop together, not empty: entry[count-1] <= data_in (replace top), count unchanged, no flag set.
REQ-020 Push and pop together while empty: treated as push only (count becomes 1, data_out = data_in next cycle), stack_underflow not set.
REQ-021 Push only while full: no write, count unchanged (no wrap-around, top preserved), stack_overflow <= 1.
REQ-022 Pop only while empty: count stays 0, stack_underflow <= 1.
REQ-023 stack_overflow and stack_underflow SHALL remain high until rst; no other event clears them.
REQ-024 Neither push nor pop: all state held.
REQ-025 count SHALL never exceed DEPTH nor go below 0 under any input sequence.

Reset
REQ-026 With rst high at a rising edge: count <= 0, stack_overflow <= 0, stack_underflow <= 0; push/pop in that cycle ignored.
REQ-027 After reset: empty = 1, full = 0, data_out = 0; entry contents are not cleared and are unobservable while empty.
REQ-028 Reset asserted mid-sequence (stack partially filled) SHALL produce the REQ-026 state at the next edge regardless of pending requests.

Verification (WIDTH=12, DEPTH=8)
REQ-029 Reset, then push 0x010, 0x020, 0x030 -> count=3, data_out=0x030; pop -> data_out=0x020 in the cycle after the pop edge, count=2.
REQ-030 Push 8 values 0x001..0x008 -> full=1, data_out=0x008; push 0x0FF -> stack_overflow=1, count=8, data_out still 0x008.
REQ-031 From empty, pop -> stack_underflow=1, count=0, data_out=0; later push 0x123 -> count=1, flag still 1.
REQ-032 With top 0x040, count=2, assert push(0x0AB) and pop together -> count=2, data_out=0x0AB; while empty, push(0x055)+pop -> count=1, data_out=0x055, no underflow.
REQ-033 Fill to count=5 with overflow and underflow flags set, assert rst one cycle with push high -> count=0, empty=1, both flags 0, data_out=0.
